// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- oversampling UART receiver with runtime-selectable parity.
//
// Takes a serial line that is already synchronised to clk, plus an
// oversampling enable (s_tick, OVS pulses per bit). It rejects false
// starts and reports one strobed word per frame, LSB first on the wire,
// with parity and framing error flags.
//
// Optional feature: define UART_RX_BREAK_DET_EN to enable break detection.
// A break is an all-zero frame (data, parity if enabled, and stop bit all
// low). It produces a break_tick pulse instead of rx_done_tick, and the
// receiver then waits for the line to go high again. When the macro is
// undefined, break_tick is tied low and a break is reported as a normal
// frame with frame_err=1.
//
// Parameters
//   DBIT    data bits per frame (5..9)
//   OVS     s_tick pulses per bit period (even, >= 8)
//   SB_TICK s_tick pulses spent in the stop state (>= OVS)
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   rx           in   serial line, idle high
//   s_tick       in   oversampling enable, one clk wide
//   parity_en    in   1: a parity bit follows the data bits
//   parity_odd   in   1: odd parity, 0: even
//   rx_done_tick out  one-clk pulse; dout and the flags are valid
//   dout         out  received word, bit0 = first bit on the wire
//   parity_err   out  parity mismatch of the last reported frame
//   frame_err    out  stop bit sampled low in the last reported frame
//   break_tick   out  one-clk pulse on a break condition
module uart_rx_cfg #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            parity_en,
  input  logic            parity_odd,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_tick
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic              pe_q, pe_d, po_q, po_d;
  logic              perr_q, perr_d, ferr_q, ferr_d, pbit_q, pbit_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
  logic              done_q, done_d;
  logic              ferr_now;
`ifdef UART_RX_BREAK_DET_EN
  logic              brk_q, brk_d;
`endif

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    pe_d       = pe_q;
    po_d       = po_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    pbit_d     = pbit_q;
    dout_d     = dout_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    done_d     = 1'b0;
    ferr_now   = ferr_q;
`ifdef UART_RX_BREAK_DET_EN
    brk_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          s_d     = '0;
          // Frame format is frozen at the start edge.
          pe_d    = parity_en;
          po_d    = parity_odd;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(OVS/2 - 1)) begin
            if (rx) begin
              state_d = IDLE;  // glitch, not a start bit
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == SW'(OVS - 1)) begin
            s_d = '0;
            b_d = {rx, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = pe_q ? PARITY : STOP;
              // Cleared so a parity-less frame reports no parity error
              // and does not block break detection.
              perr_d  = 1'b0;
              pbit_d  = 1'b0;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == SW'(OVS - 1)) begin
            perr_d  = rx ^ (^b_q) ^ po_q;
            pbit_d  = rx;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          // When SB_TICK == OVS the stop-bit centre and the end of the
          // stop state fall on the same tick, so use the live sample.
          if (s_q == SW'(OVS - 1)) begin
            ferr_d   = ~rx;
            ferr_now = ~rx;
          end
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
`ifdef UART_RX_BREAK_DET_EN
            if (b_q == '0 && !pbit_q && ferr_now) begin
              state_d = BRK;
              brk_d   = 1'b1;
            end else begin
              done_d     = 1'b1;
              dout_d     = b_q;
              perr_out_d = perr_q;
              ferr_out_d = ferr_now;
            end
`else
            done_d     = 1'b1;
            dout_d     = b_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_now;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      BRK: begin
        // Hold off until the line is released so the low level is not
        // mistaken for a new start bit.
        if (s_tick && rx) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      pe_q       <= 1'b0;
      po_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      pbit_q     <= 1'b0;
      dout_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      pe_q       <= pe_d;
      po_q       <= po_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      pbit_q     <= pbit_d;
      dout_q     <= dout_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      done_q     <= done_d;
`ifdef UART_RX_BREAK_DET_EN
      brk_q      <= brk_d;
`endif
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign parity_err   = perr_out_q;
  assign frame_err    = ferr_out_q;
`ifdef UART_RX_BREAK_DET_EN
  assign break_tick   = brk_q;
`else
  assign break_tick   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] tcnt = 2'd0;
  logic s_tick;

  logic rx_a = 1'b1, pe_a = 1'b0, po_a = 1'b0;
  logic done_a, perr_a, ferr_a, brk_a;
  logic [7:0] dout_a;

  logic rx_b = 1'b1, pe_b = 1'b0, po_b = 1'b0;
  logic done_b, perr_b, ferr_b, brk_b;
  logic [6:0] dout_b;

  int total = 0;
  int bad = 0;
  int brk_cnt_a = 0;
  int brk_exp_a = 0;

  typedef struct {
    logic [8:0] dout;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign s_tick = (tcnt == 2'd3);

  uart_rx_cfg #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick),
    .parity_en(pe_a), .parity_odd(po_a),
    .rx_done_tick(done_a), .dout(dout_a), .parity_err(perr_a),
    .frame_err(ferr_a), .break_tick(brk_a)
  );

  uart_rx_cfg #(.DBIT(7), .OVS(16), .SB_TICK(32)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick),
    .parity_en(pe_b), .parity_odd(po_b),
    .rx_done_tick(done_b), .dout(dout_b), .parity_err(perr_b),
    .frame_err(ferr_b), .break_tick(brk_b)
  );

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Returns just after (#1) the next posedge on which s_tick is high.
  task automatic wait_tick();
    forever begin
      @(negedge clk);
      if (s_tick) begin
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx_a = v;
    else rx_b = v;
  endtask

  // Push the expectation, then drive one frame, each bit OVS=16 ticks long.
  // A low stop bit is held only 8 ticks so the line is high again before
  // the receiver returns to IDLE.
  task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                            input bit par, input logic pbit, input logic stopb,
                            input logic [8:0] edout, input logic ep, input logic ef,
                            input bit flip);
    exp_t e;
    e.dout = edout;
    e.perr = ep;
    e.ferr = ef;
    if (inst == 0) qa.push_back(e);
    else qb.push_back(e);
    set_rx(inst, 1'b0);
    wait_ticks(16);
    if (flip) begin
      pe_a = ~pe_a;
      po_a = ~po_a;
    end
    for (int i = 0; i < nbits; i++) begin
      set_rx(inst, data[i]);
      wait_ticks(16);
    end
    if (par) begin
      set_rx(inst, pbit);
      wait_ticks(16);
    end
    if (stopb) begin
      set_rx(inst, 1'b1);
      wait_ticks(40);
    end else begin
      set_rx(inst, 1'b0);
      wait_ticks(8);
      set_rx(inst, 1'b1);
      wait_ticks(40);
    end
  endtask

  // Monitor: pops one expectation per strobed frame.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done_a) begin
        if (qa.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done_a got=%h want=no_pulse", dout_a);
        end else begin
          e = qa.pop_front();
          $display("frame A dout=%h perr=%b ferr=%b", dout_a, perr_a, ferr_a);
          chk("A.dout", {1'b0, dout_a}, e.dout);
          chk("A.perr", {8'd0, perr_a}, {8'd0, e.perr});
          chk("A.ferr", {8'd0, ferr_a}, {8'd0, e.ferr});
        end
      end
      if (done_b) begin
        if (qb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done_b got=%h want=no_pulse", dout_b);
        end else begin
          e = qb.pop_front();
          $display("frame B dout=%h perr=%b ferr=%b", dout_b, perr_b, ferr_b);
          chk("B.dout", {2'b00, dout_b}, e.dout);
          chk("B.perr", {8'd0, perr_b}, {8'd0, e.perr});
          chk("B.ferr", {8'd0, ferr_b}, {8'd0, e.ferr});
        end
      end
      if (brk_a) begin
        brk_cnt_a++;
        $display("break A");
      end
      if (brk_b) begin
        total++;
        bad++;
        $display("FAIL unexpected_break_b got=1 want=0");
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.dout_a", {1'b0, dout_a}, 9'h000);
    chk("rst.perr_a", {8'd0, perr_a}, 9'h000);
    chk("rst.ferr_a", {8'd0, ferr_a}, 9'h000);
    chk("rst.done_a", {8'd0, done_a}, 9'h000);
    chk("rst.brk_a",  {8'd0, brk_a},  9'h000);
    chk("rst.dout_b", {2'b00, dout_b}, 9'h000);
    chk("rst.done_b", {8'd0, done_b}, 9'h000);
    reset = 1'b0;
    wait_ticks(4);

    // 8N1 0xA5
    pe_a = 1'b0; po_a = 1'b0;
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 0);

    // 0x5A, even parity with a wrong parity bit, stop bit low
    pe_a = 1'b1; po_a = 1'b0;
    send_frame(0, 9'h05A, 8, 1, 1'b1, 1'b0, 9'h05A, 1'b1, 1'b1, 0);

    // Reset pulse during data bit 3 aborts the frame with no pulse
    pe_a = 1'b0;
    set_rx(0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      set_rx(0, i[0]);
      wait_ticks(16);
    end
    set_rx(0, 1'b0);
    wait_ticks(8);
    reset = 1'b1;
    rx_a = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst.dout_a", {1'b0, dout_a}, 9'h000);
    chk("midrst.perr_a", {8'd0, perr_a}, 9'h000);
    chk("midrst.ferr_a", {8'd0, ferr_a}, 9'h000);
    chk("midrst.done_a", {8'd0, done_a}, 9'h000);
    wait_ticks(40);
    send_frame(0, 9'h081, 8, 0, 1'b0, 1'b1, 9'h081, 1'b0, 1'b0, 0);

    // Even parity, 0x03 with parity bit 1; config flipped mid-frame must be ignored
    pe_a = 1'b1; po_a = 1'b0;
    send_frame(0, 9'h003, 8, 1, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0, 1);

    // Good frame after errors clears both flags
    pe_a = 1'b0; po_a = 1'b0;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 9'h011, 1'b0, 1'b0, 0);

    // False start: low for 4 ticks, then a good 0x3C frame
    set_rx(0, 1'b0);
    wait_ticks(4);
    set_rx(0, 1'b1);
    wait_ticks(24);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b0, 0);

`ifdef UART_RX_BREAK_DET_EN
    // Line held low for three frame times: one break, no frame
    brk_exp_a = 1;
    set_rx(0, 1'b0);
    wait_ticks(480);
    set_rx(0, 1'b1);
    wait_ticks(40);
    send_frame(0, 9'h055, 8, 0, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0, 0);
`else
    // All-zero frame with stop low is a normal frame with frame_err
    brk_exp_a = 0;
    send_frame(0, 9'h000, 8, 0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 0);
    send_frame(0, 9'h055, 8, 0, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0, 0);
`endif

    // DBIT=7, odd parity, two stop bits: 0x7F with parity 0 is correct
    pe_b = 1'b1; po_b = 1'b1;
    send_frame(1, 9'h07F, 7, 1, 1'b0, 1'b1, 9'h07F, 1'b0, 1'b0, 0);
    // Even parity: 0x2A has three ones, parity bit 0 is wrong
    pe_b = 1'b1; po_b = 1'b0;
    send_frame(1, 9'h02A, 7, 1, 1'b0, 1'b1, 9'h02A, 1'b1, 1'b0, 0);

    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("pending_a", 9'(qa.size()), 9'd0);
    chk("pending_b", 9'(qb.size()), 9'd0);
    chk("break_count_a", 9'(brk_cnt_a), 9'(brk_exp_a));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
